rfsoc_axis_router: RTL and testbench

Parametrised successor to the fixed 16-channel PS↔PL routing path. It accepts a narrow PS AXI-Stream and packs it into DAC-width words. Each packed word is routed to one of N_CH DAC-driver inputs, chosen by a GPIO-selected channel index. The same index selects one ADC-driver output, which is unpacked back to PS width for readout. It sits between the PS DMA streams and the per-channel dac_driver/adc_driver instances, replacing the separate selector, width-converter and mux stages with one select-change-safe block.

---
 rtl/rfsoc_axis_router.sv | 252 +++++++++++++++++++++++++
 tb/tb_rfsoc_axis_router.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfsoc_axis_router.sv
// rfsoc_axis_router
//   Routes a narrow PS AXI-Stream to one of N_CH DAC-driver inputs (packed to
//   DAC_W) and returns one ADC-driver stream to the PS (unpacked to PS_W).
//   The channel is chosen by gpio_ctrl; select changes never split or lose words.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   gpio_ctrl[15:0]     [15] select enable, [CH_BITS-1:0] channel index
//   s_axis_*            PS_W stream from the PS (packed LSB-first)
//   m_axis_*            N_CH x DAC_W streams to DAC drivers, slice c*DAC_W
//   s_adc_axis_*        N_CH x ADC_W streams from ADC drivers
//   m_ps_axis_*         PS_W readback stream, lane 0 first
//   busy                DAC path not idle, or a readback word still held
//
// Build option
//   RFSOC_ROUTER_DBG_EN adds dbg_axis_tdata/dbg_axis_tvalid (mirror of the DAC
//   output register) and dbg_drop_cnt (saturating count of beats dropped in IDLE).

module rfsoc_axis_router #(
  parameter int N_CH    = 16,
  parameter int PS_W    = 32,
  parameter int DAC_W   = 256,
  parameter int ADC_W   = 128,
  parameter int CH_BITS = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             gpio_ctrl,
  input  logic [PS_W-1:0]         s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [N_CH*DAC_W-1:0]   m_axis_tdata,
  output logic [N_CH-1:0]         m_axis_tvalid,
  input  logic [N_CH-1:0]         m_axis_tready,
  input  logic [N_CH*ADC_W-1:0]   s_adc_axis_tdata,
  input  logic [N_CH-1:0]         s_adc_axis_tvalid,
  output logic [N_CH-1:0]         s_adc_axis_tready,
  output logic [PS_W-1:0]         m_ps_axis_tdata,
  output logic                    m_ps_axis_tvalid,
  input  logic                    m_ps_axis_tready,
  output logic                    busy
`ifdef RFSOC_ROUTER_DBG_EN
  ,
  output logic [DAC_W-1:0]        dbg_axis_tdata,
  output logic                    dbg_axis_tvalid,
  output logic [31:0]             dbg_drop_cnt
`endif
);

  localparam int RATIO   = DAC_W / PS_W;
  localparam int RATIO_A = ADC_W / PS_W;
  localparam int PC_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int RB_W    = (RATIO_A > 1) ? $clog2(RATIO_A) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUTE, ST_FLUSH} state_t;

  logic [15:0]        gpio_q;
  state_t             state_q, state_d;
  logic [CH_BITS-1:0] active_ch_q, active_ch_d;
  logic [PC_W-1:0]    pack_cnt_q, pack_cnt_d;
  logic [DAC_W-1:0]   pack_buf_q, pack_buf_d;
  logic [DAC_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [ADC_W-1:0]   rb_data_q, rb_data_d;
  logic [RB_W-1:0]    rb_lane_q, rb_lane_d;
  logic               rb_valid_q, rb_valid_d;

  logic [CH_BITS-1:0] sel_idx;
  logic               sel_valid, sel_changed;
  logic               out_fire, out_free, last_beat, s_rdy;
  logic               ps_fire, rb_last, rb_free;
  logic [ADC_W-1:0]   adc_word;

  // Any non-zero bit above the index field makes the request out of range.
  assign sel_idx     = gpio_q[CH_BITS-1:0];
  assign sel_valid   = gpio_q[15] && (32'(gpio_q[14:0]) < N_CH);
  assign sel_changed = !sel_valid || (sel_idx != active_ch_q);

  assign out_fire  = out_valid_q && m_axis_tready[active_ch_q];
  assign out_free  = !out_valid_q || out_fire;
  assign last_beat = (pack_cnt_q == PC_W'(RATIO - 1));

  always_comb begin : dac_path
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    state_d     = state_q;
    active_ch_d = active_ch_q;
    pack_cnt_d  = pack_cnt_q;
    pack_buf_d  = pack_buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    s_rdy       = 1'b0;

    // Emptied output register returns to zero so idle slices read as 0.
    if (out_fire) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end

    case (state_q)
      ST_IDLE: begin
        s_rdy = 1'b1;  // beats are swallowed while nothing is selected
        if (sel_valid) begin
          state_d     = ST_ROUTE;
          active_ch_d = sel_idx;
        end
      end
      ST_ROUTE: begin
        if (sel_changed) begin
          // Stop accepting; a partial word is flushed to the old channel first.
          if (pack_cnt_q != '0) begin
            state_d = ST_FLUSH;
          end else if (out_free) begin
            if (sel_valid) active_ch_d = sel_idx;
            else           state_d     = ST_IDLE;
          end
        end else begin
          // Stall only when this beat would complete a word with nowhere to go.
          s_rdy = !(last_beat && !out_free);
          if (s_axis_tvalid && s_rdy) begin
            pack_buf_d[pack_cnt_q*PS_W +: PS_W] = s_axis_tdata;
            if (last_beat) begin
              out_data_d  = pack_buf_d;
              out_valid_d = 1'b1;
              pack_buf_d  = '0;
              pack_cnt_d  = '0;
            end else begin
              pack_cnt_d = pack_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (pack_cnt_q != '0) begin
          // Unwritten upper lanes of pack_buf are already zero.
          if (out_free) begin
            out_data_d  = pack_buf_q;
            out_valid_d = 1'b1;
            pack_buf_d  = '0;
            pack_cnt_d  = '0;
          end
        end else if (out_free) begin
          if (sel_valid) begin
            state_d     = ST_ROUTE;
            active_ch_d = sel_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_axis_tready = s_rdy && !rst;

  always_comb begin : dac_out
    m_axis_tvalid = '0;
    m_axis_tdata  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (CH_BITS'(c) == active_ch_q) begin
        m_axis_tvalid[c]                = out_valid_q;
        m_axis_tdata[c*DAC_W +: DAC_W] = out_data_q;
      end
    end
  end

  // Readback: the holding register keeps the whole word, so a select change
  // mid-word cannot cut it short; a new word is taken only when it drains.
  assign ps_fire = rb_valid_q && m_ps_axis_tready;
  assign rb_last = (rb_lane_q == RB_W'(RATIO_A - 1));
  assign rb_free = !rb_valid_q || (ps_fire && rb_last);

  always_comb begin : adc_path
    adc_word = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (CH_BITS'(c) == sel_idx) adc_word = s_adc_axis_tdata[c*ADC_W +: ADC_W];
    end
    s_adc_axis_tready = '0;
    if (!rst && sel_valid && rb_free) s_adc_axis_tready[sel_idx] = 1'b1;

    rb_data_d  = rb_data_q;
    rb_lane_d  = rb_lane_q;
    rb_valid_d = rb_valid_q;
    if (ps_fire) begin
      rb_data_d = rb_data_q >> PS_W;  // next lane moves into the low bits
      rb_lane_d = rb_lane_q + 1'b1;
      if (rb_last) begin
        rb_valid_d = 1'b0;
        rb_lane_d  = '0;
      end
    end
    if (sel_valid && rb_free && s_adc_axis_tvalid[sel_idx]) begin
      rb_data_d  = adc_word;
      rb_valid_d = 1'b1;
      rb_lane_d  = '0;
    end
  end

  assign m_ps_axis_tdata  = rb_data_q[PS_W-1:0];
  assign m_ps_axis_tvalid = rb_valid_q;
  assign busy             = (state_q != ST_IDLE) || rb_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are reset too: flush padding and idle outputs rely on zeros.
      gpio_q      <= '0;
      state_q     <= ST_IDLE;
      active_ch_q <= '0;
      pack_cnt_q  <= '0;
      pack_buf_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rb_data_q   <= '0;
      rb_lane_q   <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      gpio_q      <= gpio_ctrl;
      state_q     <= state_d;
      active_ch_q <= active_ch_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_buf_q  <= pack_buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rb_data_q   <= rb_data_d;
      rb_lane_q   <= rb_lane_d;
      rb_valid_q  <= rb_valid_d;
    end
  end

`ifdef RFSOC_ROUTER_DBG_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (state_q == ST_IDLE && s_axis_tvalid && s_axis_tready && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign dbg_axis_tdata  = out_data_q;
  assign dbg_axis_tvalid = out_valid_q;
  assign dbg_drop_cnt    = drop_cnt_q;
`else
  // Debug mirror and drop counter are not built.
`endif

endmodule

// File: tb/tb_rfsoc_axis_router.sv
// Directed bench for rfsoc_axis_router at N_CH=8, PS_W=32, DAC_W=256, ADC_W=128.
module tb_rfsoc_axis_router;

  localparam int N_CH  = 8;
  localparam int PS_W  = 32;
  localparam int DAC_W = 256;
  localparam int ADC_W = 128;

  logic                  clk;
  logic                  rst;
  logic [15:0]           gpio_ctrl;
  logic [PS_W-1:0]       s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [N_CH*DAC_W-1:0] m_axis_tdata;
  logic [N_CH-1:0]       m_axis_tvalid;
  logic [N_CH-1:0]       m_axis_tready;
  logic [N_CH*ADC_W-1:0] s_adc_axis_tdata;
  logic [N_CH-1:0]       s_adc_axis_tvalid;
  logic [N_CH-1:0]       s_adc_axis_tready;
  logic [PS_W-1:0]       m_ps_axis_tdata;
  logic                  m_ps_axis_tvalid;
  logic                  m_ps_axis_tready;
  logic                  busy;
`ifdef RFSOC_ROUTER_DBG_EN
  logic [DAC_W-1:0]      dbg_axis_tdata;
  logic                  dbg_axis_tvalid;
  logic [31:0]           dbg_drop_cnt;
`endif

  rfsoc_axis_router #(.N_CH(N_CH), .PS_W(PS_W), .DAC_W(DAC_W), .ADC_W(ADC_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .gpio_ctrl         (gpio_ctrl),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .s_adc_axis_tdata  (s_adc_axis_tdata),
    .s_adc_axis_tvalid (s_adc_axis_tvalid),
    .s_adc_axis_tready (s_adc_axis_tready),
    .m_ps_axis_tdata   (m_ps_axis_tdata),
    .m_ps_axis_tvalid  (m_ps_axis_tvalid),
    .m_ps_axis_tready  (m_ps_axis_tready),
    .busy              (busy)
`ifdef RFSOC_ROUTER_DBG_EN
    ,
    .dbg_axis_tdata    (dbg_axis_tdata),
    .dbg_axis_tvalid   (dbg_axis_tvalid),
    .dbg_drop_cnt      (dbg_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               ch;
    logic [DAC_W-1:0] data;
  } dac_rec_t;

  dac_rec_t         dac_q[$];
  logic [PS_W-1:0]  ps_q[$];
  int               n_checks = 0;
  int               n_bad    = 0;
  int               viol_dac = 0;
  int               viol_ps  = 0;
  logic             hold_dac = 1'b0;
  logic             hold_ps  = 1'b0;
  logic [N_CH-1:0]       prev_valid;
  logic [N_CH*DAC_W-1:0] prev_data;
  logic [PS_W-1:0]       prev_ps;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word whose first n lanes hold first, first+1, ...; upper lanes zero.
  function automatic logic [255:0] lanes(input logic [31:0] first, input int n);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[k*32 +: 32] = first + 32'(k);
    return w;
  endfunction

  // Monitor: log handshakes and flag any held word that moves before acceptance.
  always @(negedge clk) begin
    if (rst) begin
      hold_dac = 1'b0;
      hold_ps  = 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (m_axis_tvalid[c] && m_axis_tready[c])
          dac_q.push_back('{c, m_axis_tdata[c*DAC_W +: DAC_W]});
      end
      if (hold_dac && (m_axis_tvalid != prev_valid || m_axis_tdata != prev_data)) viol_dac++;
      hold_dac   = |(m_axis_tvalid & ~m_axis_tready);
      prev_valid = m_axis_tvalid;
      prev_data  = m_axis_tdata;
      if (m_ps_axis_tvalid && m_ps_axis_tready) ps_q.push_back(m_ps_axis_tdata);
      if (hold_ps && (!m_ps_axis_tvalid || m_ps_axis_tdata != prev_ps)) viol_ps++;
      hold_ps = m_ps_axis_tvalid && !m_ps_axis_tready;
      prev_ps = m_ps_axis_tdata;
    end
  end

  // Present one PS beat and wait (bounded) for it to be accepted.
  task automatic send_beat(input logic [31:0] d, output int waits);
    bit done;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (s_axis_tready) done = 1'b1;
      else begin
        waits++;
        if (waits > 300) begin
          check("beat_timeout", 256'(waits), 256'(0));
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic expect_dac(input string tag, input int ch, input logic [255:0] data);
    dac_rec_t rec;
    rec.ch   = -1;
    rec.data = '1;
    if (dac_q.size() > 0) rec = dac_q.pop_front();
    check({tag, "_ch"}, 256'(rec.ch), 256'(ch));
    check({tag, "_data"}, rec.data, data);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] others_nz(input int keep);
    logic [255:0] acc;
    acc = '0;
    for (int c = 0; c < N_CH; c++) if (c != keep) acc |= m_axis_tdata[c*DAC_W +: DAC_W];
    return acc;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, stalls, got, k;
    logic        rdy_seen;
    logic [31:0] obs_lane;
    logic [31:0] exp_ps[8];

    rst = 1'b1; gpio_ctrl = '0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    m_axis_tready = '1; s_adc_axis_tdata = '0; s_adc_axis_tvalid = '0; m_ps_axis_tready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 256'(s_axis_tready), 256'(0));
    check("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("rst_m_tdata_nz", 256'(|m_axis_tdata), 256'(0));
    check("rst_ps_tvalid", 256'(m_ps_axis_tvalid), 256'(0));
    check("rst_ps_tdata", 256'(m_ps_axis_tdata), 256'(0));
    check("rst_adc_tready", 256'(s_adc_axis_tready), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", 256'(s_axis_tready), 256'(1));
    @(posedge clk); #1;

    // Sel=3, 16 beats -> two words on ch3
    gpio_ctrl = 16'h8003;
    cycles(3);
    for (int i = 1; i <= 16; i++) begin
      send_beat(32'(i), w);
      if (i == 8) begin
        check("t1_w0_valid", 256'(m_axis_tvalid), 256'(8'h08));
        check("t1_w0_data", m_axis_tdata[3*DAC_W +: DAC_W], lanes(32'h1, 8));
        check("t1_w0_others", others_nz(3), 256'(0));
      end
      if (i == 16) begin
        check("t1_w1_valid", 256'(m_axis_tvalid), 256'(8'h08));
        check("t1_w1_data", m_axis_tdata[3*DAC_W +: DAC_W], lanes(32'h9, 8));
      end
    end
    cycles(3);
    check("t1_count", 256'(dac_q.size()), 256'(2));
    expect_dac("t1_word0", 3, lanes(32'h1, 8));
    expect_dac("t1_word1", 3, lanes(32'h9, 8));

    // Sel none: everything dropped at full rate
    gpio_ctrl = 16'h0003;
    cycles(3);
    check("t2_busy", 256'(busy), 256'(0));
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      send_beat(32'h700 + 32'(i), w);
      stalls += w;
    end
    cycles(3);
    check("t2_stalls", 256'(stalls), 256'(0));
    check("t2_count", 256'(dac_q.size()), 256'(0));
`ifdef RFSOC_ROUTER_DBG_EN
    check("t2_drop_cnt", 256'(dbg_drop_cnt), 256'(10));
`endif

    // Sel=2, 3 beats, then switch to 5: zero-padded flush to ch2
    gpio_ctrl = 16'h8002;
    m_axis_tready = 8'hFB;
    cycles(3);
    send_beat(32'hA, w);
    send_beat(32'hB, w);
    send_beat(32'hC, w);
    gpio_ctrl = 16'h8005;
    cycles(2);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h51;
    rdy_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      rdy_seen |= s_axis_tready;
    end
    check("t3_s_tready_held", 256'(rdy_seen), 256'(0));
    check("t3_flush_valid", 256'(m_axis_tvalid), 256'(8'h04));
    check("t3_flush_data", m_axis_tdata[2*DAC_W +: DAC_W], lanes(32'hA, 3));
    check("t3_busy", 256'(busy), 256'(1));
    @(posedge clk); #1;
    m_axis_tready = 8'hFF;
    for (int i = 0; i < 8; i++) send_beat(32'h51 + 32'(i), w);
    cycles(3);
    check("t3_count", 256'(dac_q.size()), 256'(2));
    expect_dac("t3_flush", 2, lanes(32'hA, 3));
    expect_dac("t3_ch5", 5, lanes(32'h51, 8));

    // Sel=1 with a 20-cycle tready stall while streaming
    gpio_ctrl = 16'h8001;
    cycles(3);
    m_axis_tready = 8'hFD;
    stalls = 0;
    fork
      begin
        int ws;
        for (int i = 0; i < 24; i++) begin
          send_beat(32'h100 + 32'(i), ws);
          stalls += ws;
        end
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        m_axis_tready = 8'hFF;
      end
    join
    cycles(4);
    check("t4_stalled", 256'(stalls > 0), 256'(1));
    check("t4_count", 256'(dac_q.size()), 256'(3));
    expect_dac("t4_word0", 1, lanes(32'h100, 8));
    expect_dac("t4_word1", 1, lanes(32'h108, 8));
    expect_dac("t4_word2", 1, lanes(32'h110, 8));

    // ADC readback on ch7, switch to ch0 mid-word
    gpio_ctrl = 16'h8007;
    cycles(3);
    m_ps_axis_tready = 1'b0;
    s_adc_axis_tdata[7*ADC_W +: ADC_W] = 128'h00004444_00003333_00002222_00001111;
    s_adc_axis_tdata[0*ADC_W +: ADC_W] = 128'h000000A3_000000A2_000000A1_000000A0;
    s_adc_axis_tvalid = 8'h81;
    @(negedge clk);
    check("t5_adc_tready_ch7", 256'(s_adc_axis_tready), 256'(8'h80));
    @(posedge clk); #1;
    s_adc_axis_tvalid = 8'h01;
    check("t5_adc_tready_full", 256'(s_adc_axis_tready), 256'(0));
    check("t5_ps_valid", 256'(m_ps_axis_tvalid), 256'(1));
    check("t5_ps_lane0", 256'(m_ps_axis_tdata), 256'(32'h1111));
    m_ps_axis_tready = 1'b1;
    @(posedge clk); #1;
    m_ps_axis_tready = 1'b0;
    gpio_ctrl = 16'h8000;
    cycles(3);
    check("t5_ps_lane1_held", 256'(m_ps_axis_tdata), 256'(32'h2222));
    check("t5_adc_tready_switch", 256'(s_adc_axis_tready), 256'(0));
    m_ps_axis_tready = 1'b1;
    got = 0; k = 0; obs_lane = '0;
    while (got == 0 && k < 50) begin
      @(negedge clk);
      if (s_adc_axis_tready[0]) begin
        got = 1;
        obs_lane = m_ps_axis_tdata;
      end
      @(posedge clk); #1;
      k++;
    end
    s_adc_axis_tvalid = '0;
    check("t5_ch0_accepted", 256'(got), 256'(1));
    check("t5_b2b_last_lane", 256'(obs_lane), 256'(32'h4444));
    cycles(6);
    exp_ps = '{32'h1111, 32'h2222, 32'h3333, 32'h4444, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
    check("t5_ps_count", 256'(ps_q.size()), 256'(8));
    for (int i = 0; i < 8; i++) begin
      obs_lane = (ps_q.size() > 0) ? ps_q.pop_front() : 32'hFFFF_FFFF;
      check($sformatf("t5_ps_beat%0d", i), 256'(obs_lane), 256'(exp_ps[i]));
    end

    // Sel=9 at N_CH=8 is "none"
    gpio_ctrl = 16'h8009;
    cycles(3);
    check("t6_busy", 256'(busy), 256'(0));
    s_adc_axis_tdata[1*ADC_W +: ADC_W] = 128'h5;
    s_adc_axis_tvalid = 8'h02;
    stalls = 0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h900 + 32'(i), w);
      stalls += w;
      rdy_seen |= |s_adc_axis_tready;
    end
    s_adc_axis_tvalid = '0;
    cycles(3);
    check("t6_stalls", 256'(stalls), 256'(0));
    check("t6_adc_tready", 256'(rdy_seen), 256'(0));
    check("t6_dac_count", 256'(dac_q.size()), 256'(0));
    check("t6_ps_count", 256'(ps_q.size()), 256'(0));

    // Reset with a held DAC word, a partial word and a held readback word
    gpio_ctrl = 16'h8004;
    cycles(3);
    m_axis_tready = '0;
    for (int i = 0; i < 10; i++) send_beat(32'h200 + 32'(i), w);
    m_ps_axis_tready = 1'b0;
    s_adc_axis_tdata[4*ADC_W +: ADC_W] = 128'h44_0000_0033;
    s_adc_axis_tvalid = 8'h10;
    @(posedge clk); #1;
    s_adc_axis_tvalid = '0;
    check("t7_pre_m_tvalid", 256'(m_axis_tvalid), 256'(8'h10));
    check("t7_pre_ps_tvalid", 256'(m_ps_axis_tvalid), 256'(1));
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_s_tready", 256'(s_axis_tready), 256'(0));
    @(posedge clk); #1;
    check("t7_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("t7_m_tdata_nz", 256'(|m_axis_tdata), 256'(0));
    check("t7_ps_tvalid", 256'(m_ps_axis_tvalid), 256'(0));
    check("t7_ps_tdata", 256'(m_ps_axis_tdata), 256'(0));
    check("t7_busy", 256'(busy), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check("t7_post_s_tready", 256'(s_axis_tready), 256'(1));
    @(posedge clk); #1;
    m_axis_tready = '1;
    m_ps_axis_tready = 1'b1;
    cycles(6);
    check("t7_dac_count", 256'(dac_q.size()), 256'(0));
    check("t7_ps_count", 256'(ps_q.size()), 256'(0));

    check("stable_dac", 256'(viol_dac), 256'(0));
    check("stable_ps", 256'(viol_ps), 256'(0));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
